// File: rtl/axis_frame_trailer.sv
// AXI-stream stage that forwards payload words with one registered cycle of latency and
// appends a per-frame trailer word holding the modulo-2^DATA_WIDTH sum of the payload.
module axis_frame_trailer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_LEN    = 256,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [CNT_W-1:0]      frame_count,
  output logic                  trunc_pulse
);

  localparam int unsigned LenW = $clog2(MAX_LEN);
  localparam logic [LenW-1:0] LastBeat = LenW'(MAX_LEN - 1);

  typedef enum logic [0:0] {StPass, StTrail} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [LenW-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]      frame_count_q, frame_count_d;
  logic                  trunc_q, trunc_d;

  logic out_free;
  logic in_fire;
  logic close_frame;

  assign out_free    = !m_tvalid_q || m_tready;
  // Gated by reset so the upstream FIFO never sees a handshake while we are held in reset.
  assign s_tready    = (state_q == StPass) && out_free && !reset;
  assign in_fire     = s_tvalid && s_tready;
  assign close_frame = s_tlast || (cnt_q == LastBeat);

  always_comb begin
    state_d       = state_q;
    m_tdata_d     = m_tdata_q;
    m_tvalid_d    = m_tvalid_q;
    m_tlast_d     = m_tlast_q;
    sum_d         = sum_q;
    cnt_d         = cnt_q;
    trunc_d       = 1'b0;
    frame_count_d = frame_count_q;

    if (m_tvalid_q && m_tlast_q && m_tready) begin
      frame_count_d = frame_count_q + CNT_W'(1);
    end

    unique case (state_q)
      StPass: begin
        if (in_fire) begin
          m_tdata_d  = s_tdata;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          sum_d      = sum_q + s_tdata;
          if (close_frame) begin
            // Counter is cleared when the trailer loads, so it never passes LastBeat.
            state_d = StTrail;
            trunc_d = !s_tlast;
          end else begin
            cnt_d = cnt_q + LenW'(1);
          end
        end else if (m_tready) begin
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
        end
      end
      StTrail: begin
        if (out_free) begin
          m_tdata_d  = sum_q;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b1;
          sum_d      = '0;
          cnt_d      = '0;
          state_d    = StPass;
        end
      end
      default: state_d = StPass;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StPass;
      m_tdata_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      sum_q         <= '0;
      cnt_q         <= '0;
      frame_count_q <= '0;
      trunc_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_tdata_q     <= m_tdata_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      frame_count_q <= frame_count_d;
      trunc_q       <= trunc_d;
    end
  end

  assign m_tdata     = m_tdata_q;
  assign m_tvalid    = m_tvalid_q;
  assign m_tlast     = m_tlast_q;
  assign frame_count = frame_count_q;
  assign trunc_pulse = trunc_q;

endmodule

// File: tb/tb_axis_frame_trailer.sv
// Directed and random-backpressure bench for axis_frame_trailer; a reference model pushes
// expected payload/trailer words into a queue that the output monitor pops and compares.
module tb_axis_frame_trailer;

  localparam int unsigned DW     = 16;
  localparam int unsigned MaxLen = 4;
  localparam int unsigned CW     = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [CW-1:0] frame_count;
  logic          trunc_pulse;

  int total = 0;
  int bad = 0;

  logic [DW:0]   exp_q[$];
  logic [DW:0]   exp_e;
  logic [DW-1:0] msum = '0;
  int            mcnt = 0;
  int            exp_frames = 0;
  int            exp_trunc = 0;
  int            seen_trunc = 0;
  bit            rand_mode = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  axis_frame_trailer #(
    .DATA_WIDTH(DW),
    .MAX_LEN   (MaxLen),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .frame_count(frame_count),
    .trunc_pulse(trunc_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic l);
    exp_q.push_back({1'b0, d});
    msum = msum + d;
    if (l || mcnt == int'(MaxLen) - 1) begin
      exp_q.push_back({1'b1, msum});
      exp_frames++;
      if (!l) exp_trunc++;
      msum = '0;
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit done;
    done = 1'b0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (s_tready) begin
        model_accept(d, l);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("send_accept", 32'(done), 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_trunc", trunc_pulse, 0);
  endtask

  // Downstream backpressure, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    m_tready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitor: stall stability, scoreboard pop on handshake, truncation pulse count.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata, prev_data);
        check("stall_last", m_tlast, prev_last);
      end
      if (trunc_pulse) seen_trunc++;
      if (m_tvalid && m_tready) begin
        check("out_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("out_data", m_tdata, exp_e[DW-1:0]);
          check("out_last", m_tlast, exp_e[DW]);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Three-beat frame, first output one cycle after first input.
    send(16'h0001, 1'b0);
    check("lat_valid", m_tvalid, 1);
    check("lat_data", m_tdata, 16'h0001);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b1);
    drain(100);
    check("fc_three", frame_count, 1);

    // Single-beat frame: input stalls exactly one cycle.
    send(16'hABCD, 1'b1);
    check("single_stall", s_tready, 0);
    @(posedge clk);
    #1;
    check("single_resume", s_tready, 1);
    drain(100);
    check("fc_single", frame_count, 2);

    // Sum wraps modulo 2^16.
    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b1);
    drain(100);
    check("fc_wrap", frame_count, 3);

    // Six beats with tlast on the sixth: forced close after four.
    for (int i = 1; i <= 6; i++) send(DW'(i), i == 6);
    drain(100);
    check("fc_maxlen", frame_count, 5);
    check("trunc_maxlen", 32'(seen_trunc), 1);

    // tlast exactly on the MaxLen-th beat closes normally.
    for (int i = 7; i <= 10; i++) send(DW'(i), i == 10);
    drain(100);
    check("fc_exact", frame_count, 6);
    check("trunc_exact", 32'(seen_trunc), 1);

    // Random backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 24000; i++) send(DW'($urandom), (i % 11) == 10);
    rand_mode = 1'b0;
    drain(1000);
    check("fc_random", frame_count, 32'(exp_frames));
    check("trunc_random", 32'(seen_trunc), 32'(exp_trunc));

    // Reset mid-frame discards the partial frame.
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    msum = '0;
    mcnt = 0;
    exp_frames = 0;
    check_reset_outputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(16'h0010, 1'b1);
    drain(100);
    check("fc_after_reset", frame_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_trailer.md
Name: axis_frame_trailer

Overview:
- AXI-stream stage directly downstream of dual_fifo; consumes its 16-bit output stream (data_out1/tvalid_out1/tlast_out1/tready_in1).
- Forwards payload words with one registered cycle of latency.
- Closes frames on input tlast, or by force after MAX_LEN beats.
- Appends one trailer word per frame carrying the modulo-2^DATA_WIDTH sum of that frame's payload, with m_tlast on the trailer only; also exposes frame and truncation status.

Parameters:
- DATA_WIDTH, 16, width of payload and trailer words.
- MAX_LEN, 256, maximum payload beats per frame before forced close (>=2).
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_tdata  in  DATA_WIDTH  input payload (from dual_fifo data_out1).
- s_tvalid  in  1  input valid (from tvalid_out1).
- s_tlast  in  1  input end-of-frame (from tlast_out1).
- s_tready  out  1  input ready (to tready_in1).
- m_tdata  out  DATA_WIDTH  output data (payload or trailer).
- m_tvalid  out  1  output valid.
- m_tlast  out  1  high only on the trailer beat.
- m_tready  in  1  downstream ready.
- frame_count  out  CNT_W  number of trailers accepted downstream; wraps to 0.
- trunc_pulse  out  1  one-cycle pulse when a frame is force-closed at MAX_LEN.

Behaviour:
Reset:
- While reset=1: m_tdata=0, m_tvalid=0, m_tlast=0, s_tready=0, frame_count=0, trunc_pulse=0.
- Internal sum=0, beat count=0, state=PASS.
- Reset mid-frame discards the partial frame and its sum; no trailer is emitted.

State machine (two states):
- Output register is free when m_tvalid=0 or m_tready=1.
- PASS:
  - s_tready = output register free (combinational).
  - On s_tvalid&&s_tready: m_tdata<=s_tdata, m_tvalid<=1, m_tlast<=0, sum<=sum+s_tdata (truncated to DATA_WIDTH), cnt<=cnt+1.
  - If s_tlast=1 or cnt==MAX_LEN-1 on that beat: go to TRAIL.
  - trunc_pulse<=1 only if cnt==MAX_LEN-1 and s_tlast=0.
  - A beat with s_tlast=1 exactly at MAX_LEN closes normally (no pulse).
  - With no input handshake and m_tready=1: m_tvalid<=0.
- TRAIL:
  - s_tready=0.
  - When the output register is free: m_tdata<=sum (already includes the last payload word), m_tvalid<=1, m_tlast<=1, sum<=0, cnt<=0, go to PASS.
  - If not free, hold in TRAIL.
- frame_count increments on the cycle the trailer handshakes (m_tvalid&&m_tlast&&m_tready).

Handshake and timing:
- m_tdata, m_tvalid and m_tlast stay stable while m_tvalid=1 and m_tready=0.
- Latency: input beat appears on m_* the next cycle.
- Steady state (m_tready=1): N payload beats cost N+1 output cycles per frame; input stalls exactly one cycle per frame.
- Payload beats are never dropped or duplicated under any m_tready pattern.
- A new frame's first beat is accepted in the cycle the trailer is loaded out (PASS re-entry) only if the register is free; otherwise it waits.

Boundary conditions:
- A single-beat frame (s_tlast on first beat) yields 2 output beats, with trailer = that word.
- sum wraps modulo 2^DATA_WIDTH.
- cnt never exceeds MAX_LEN-1.
- s_tlast is ignored when s_tvalid=0.

Test Plan:
- Frame 0x0001,0x0002,0x0003 (tlast on 0x0003), m_tready=1 -> out 0x0001,0x0002,0x0003,0x0006(tlast); first output 1 cycle after first input; frame_count=1.
- Single beat 0xABCD with tlast -> out 0xABCD, 0xABCD(tlast); s_tready low for exactly 1 cycle.
- Wrap: 0xFFFF,0x0002 tlast -> trailer 0x0001.
- MAX_LEN=4, 6 beats 1..6 with tlast on beat 6:
  - Out 1,2,3,4, trailer 0x000A(tlast), with trunc_pulse high 1 cycle.
  - Then 5,6, trailer 0x000B(tlast).
  - frame_count=2.
- Random m_tready (50%) over 24000 words with tlast every 11th input:
  - Output payload order and content match the input.
  - Every trailer equals its frame sum; m_* stable during stalls.
- Reset asserted after 2 beats of a frame, then a fresh frame 0x0010 tlast -> no stale trailer; out 0x0010, 0x0010(tlast); frame_count=1.
